// File: rtl/batch_accumulator_if.sv
// Stream bundle around batch_accumulator: the sample input stream and the
// batch-sum output stream. The block itself connects through the slave
// modport; the producer/sink side uses the master modport.
interface batch_accumulator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 21
);
  logic [DATA_WIDTH-1:0] s_axis_input_tdata;
  logic                  s_axis_input_tvalid;
  logic                  s_axis_input_tlast;
  logic                  s_axis_input_tready;
  logic [ACC_WIDTH-1:0]  m_axis_output_tdata;
  logic                  m_axis_output_tvalid;
  logic                  m_axis_output_tlast;
  logic                  m_axis_output_tready;

  modport slave (
    input  s_axis_input_tdata, s_axis_input_tvalid, s_axis_input_tlast,
    input  m_axis_output_tready,
    output s_axis_input_tready,
    output m_axis_output_tdata, m_axis_output_tvalid, m_axis_output_tlast
  );

  modport master (
    output s_axis_input_tdata, s_axis_input_tvalid, s_axis_input_tlast,
    output m_axis_output_tready,
    input  s_axis_input_tready,
    input  m_axis_output_tdata, m_axis_output_tvalid, m_axis_output_tlast
  );
endinterface

// File: rtl/batch_accumulator.sv
// batch_accumulator: sums groups of BATCH_SIZE signed samples and emits one
// widened sum per group. An input tlast closes the group early; the sum then
// carries tlast. Two states: ACCUM takes samples, EMIT holds the sum until
// the sink takes it. Input ready is a flop, so it never depends
// combinationally on the output ready.
module batch_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int BATCH_SIZE = 32,
  parameter int ACC_WIDTH  = 21
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  batch_accumulator_if.slave axis
);

  localparam int CNT_WIDTH = $clog2(BATCH_SIZE + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BATCH_SIZE - 1);

  // Parameter sanity: a too-narrow accumulator could wrap on a full batch.
  generate
    if (BATCH_SIZE < 1) begin : g_bad_batch
      $error("batch_accumulator: BATCH_SIZE must be at least 1");
    end
    if (ACC_WIDTH < DATA_WIDTH + $clog2(BATCH_SIZE)) begin : g_bad_acc
      $error("batch_accumulator: ACC_WIDTH too narrow for DATA_WIDTH and BATCH_SIZE");
    end
  endgenerate

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   sum_q, sum_d;
  logic                   last_q, last_d;
  logic                   in_ready_q, in_ready_d;

  logic [DATA_WIDTH-1:0]  sample;
  logic [ACC_WIDTH-1:0]   sample_ext;
  logic [ACC_WIDTH-1:0]   acc_plus;
  logic                   accept;

  assign sample     = axis.s_axis_input_tdata;
  assign sample_ext = ACC_WIDTH'($signed(sample));
  assign acc_plus   = acc_q + sample_ext;
  assign accept     = axis.s_axis_input_tvalid & in_ready_q;

  assign axis.s_axis_input_tready  = in_ready_q;
  assign axis.m_axis_output_tvalid = (state_q == ST_EMIT);
  assign axis.m_axis_output_tdata  = sum_q;
  assign axis.m_axis_output_tlast  = last_q;

  // Next-state logic: accumulate, close a batch into the output register, release on handshake.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    last_d     = last_q;
    in_ready_d = in_ready_q;
    unique case (state_q)
      ST_ACCUM: begin
        // Ready comes up on the first edge out of reset and stays up in ACCUM.
        in_ready_d = 1'b1;
        if (accept) begin
          if ((cnt_q == CNT_LAST) || axis.s_axis_input_tlast) begin
            sum_d      = acc_plus;
            last_d     = axis.s_axis_input_tlast;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = ST_EMIT;
            in_ready_d = 1'b0;
          end else begin
            acc_d = acc_plus;
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      ST_EMIT: begin
        // Sum and tlast stay frozen until the sink takes them.
        in_ready_d = 1'b0;
        if (axis.m_axis_output_tready) begin
          state_d    = ST_ACCUM;
          in_ready_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_ACCUM;
        in_ready_d = 1'b0;
      end
    endcase
  end

  // State register; reset discards any partial batch and pending sum.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= ST_ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      last_q     <= last_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule
